// File: rtl/delay_arbiter_pkg.sv
// Shared state encodings and limits for the delay-counter arbiter.
package delay_arbiter_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/delay_arbiter_rr_picker.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping to 0.
// Latency 0; no backpressure, valid simply mirrors |req.
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    valid = |req;
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
      // Explicit wrap so non-power-of-two NUM_REQ never visits an unused index
      cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + IW'(1);
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin owner of the shared one-second delay_counter; LOAD->WAIT->DONE per grant, one-cycle done pulse.
// Grant 1 cycle after req; requesters hold req until done. Optional DELAY_ABORT_EN: dropping req cancels the delay.
module delay_arbiter
  import delay_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic               ld_delay,
  output logic               delayEN,
  input  logic               delay_done
);

  localparam int IW = $clog2(NUM_REQ);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] owner_next;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic          abort;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign owner_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

`ifdef DELAY_ABORT_EN
  assign abort = !req[owner];
`else
  assign abort = 1'b0;
`endif

  assign ld_delay = (state == ST_LOAD);
  assign delayEN  = (state == ST_WAIT);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE) ? grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state <= ST_LOAD;
            grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            owner <= pick_idx;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= owner_next;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // delay_done only counts here; LOAD has already cleared any stale level
          if (abort) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= owner_next;
          end else if (delay_done) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          ptr   <= owner_next;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter with a delay_counter stub and a queue-based scoreboard.
module tb_delay_arbiter;

  localparam int N        = 4;
  localparam int WAIT_LEN = 6;  // delayEN cycles: 5 to raise delay_done, 1 to sample it

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic         busy;
  logic         ld_delay;
  logic         delayEN;
  logic         delay_done;

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;
  int en_cnt = 0;

  logic [N-1:0] exp_grant_q[$];
  logic [N-1:0] exp_done_q[$];

  delay_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .ld_delay   (ld_delay),
    .delayEN    (delayEN),
    .delay_done (delay_done)
  );

  always #5 clk = ~clk;

  // delay_counter stub: no reset, so delay_done starts and stays stale-high until reloaded
  int stub_cnt = 0;
  initial delay_done = 1'b1;
  always @(posedge clk) begin
    if (ld_delay) begin
      stub_cnt   <= 0;
      delay_done <= 1'b0;
    end else if (delayEN && !delay_done) begin
      if (stub_cnt == 4) delay_done <= 1'b1;
      stub_cnt <= stub_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT loads the counter or pulses done
  logic prev_ld = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      en_cnt    = 0;
      prev_ld   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_ld) begin
        chk("load_once_ld", {31'd0, ld_delay}, 32'd0);
      end
      if (prev_done) begin
        chk("idle_gap_busy", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {28'd0, done}, 32'd0);
      end
      if (ld_delay) begin
        en_cnt = 0;
        if (exp_grant_q.size() == 0) chk("unexpected_grant", {28'd0, grant}, 32'd0);
        else chk("grant", {28'd0, grant}, {28'd0, exp_grant_q.pop_front()});
      end
      if (delayEN) en_cnt++;
      if (done != '0) begin
        done_seen++;
        if (exp_done_q.size() == 0) chk("unexpected_done", {28'd0, done}, 32'd0);
        else chk("done", {28'd0, done}, {28'd0, exp_done_q.pop_front()});
        chk("wait_len", en_cnt, WAIT_LEN);
      end
      prev_ld   = ld_delay;
      prev_done = (done != '0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_seen < target && k < 200) begin
      step();
      k++;
    end
    if (done_seen < target) chk("timeout_done", done_seen, target);
  endtask

  task automatic wait_en(input int cycles);
    int k = 0;
    while (!(delayEN && en_cnt >= cycles) && k < 200) begin
      step();
      k++;
    end
    if (!(delayEN && en_cnt >= cycles)) chk("timeout_wait", en_cnt, cycles);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  int tgt;

  initial begin
    reset = 1'b1;
    req   = '0;
    repeat (3) step();
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ld", {31'd0, ld_delay}, 32'd0);
    chk("rst_en", {31'd0, delayEN}, 32'd0);
    reset = 1'b0;
    step();

    // Single requester, first op sees a stale-high delay_done
    tgt = done_seen;
    exp_grant_q.push_back(4'b0100);
    exp_done_q.push_back(4'b0100);
    req = 4'b0100;
    wait_done(++tgt);
    req = '0;
    repeat (3) step();
    chk("idle_after_single", {31'd0, busy}, 32'd0);

    // ptr now 3: wrap-around order 3 then 0
    exp_grant_q.push_back(4'b1000);
    exp_done_q.push_back(4'b1000);
    exp_grant_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    req = 4'b1001;
    wait_done(++tgt);
    req = 4'b0001;
    wait_done(++tgt);
    req = '0;
    repeat (3) step();

    // All requesting from ptr 0: strict rotation, requester 0 re-served last
    do_reset();
    step();
    foreach (exp_done_q[i]) ;
    exp_grant_q.push_back(4'b0001); exp_done_q.push_back(4'b0001);
    exp_grant_q.push_back(4'b0010); exp_done_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b0100); exp_done_q.push_back(4'b0100);
    exp_grant_q.push_back(4'b1000); exp_done_q.push_back(4'b1000);
    exp_grant_q.push_back(4'b0001); exp_done_q.push_back(4'b0001);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_done(++tgt);
    req = '0;
    repeat (3) step();

    // Reset in the middle of WAIT: drop everything, no done pulse
    exp_grant_q.push_back(4'b0010);
    req = 4'b0010;
    wait_en(2);
    reset = 1'b1;
    req   = '0;
    step();
    chk("midrst_grant", {28'd0, grant}, 32'd0);
    chk("midrst_en", {31'd0, delayEN}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {28'd0, done}, 32'd0);
    reset = 1'b0;
    step();
    exp_grant_q.push_back(4'b1000);
    exp_done_q.push_back(4'b1000);
    req = 4'b1000;
    wait_done(++tgt);
    req = '0;
    repeat (3) step();

    // Owner drops req mid-WAIT (ptr is 0 here)
    exp_grant_q.push_back(4'b0010);
`ifdef DELAY_ABORT_EN
    exp_grant_q.push_back(4'b0100);
    exp_done_q.push_back(4'b0100);
    req = 4'b0110;
    wait_en(2);
    req = 4'b0100;
    step();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_grant", {28'd0, grant}, 32'd0);
    chk("abort_done", {28'd0, done}, 32'd0);
    wait_done(++tgt);
`else
    exp_done_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b0100);
    exp_done_q.push_back(4'b0100);
    req = 4'b0110;
    wait_en(2);
    req = 4'b0100;
    step();
    chk("noabort_busy", {31'd0, busy}, 32'd1);
    chk("noabort_grant", {28'd0, grant}, 32'd2);
    wait_done(++tgt);
    wait_done(++tgt);
`endif
    req = '0;
    repeat (5) step();

    chk("grant_q_drained", exp_grant_q.size(), 0);
    chk("done_q_drained", exp_done_q.size(), 0);
    chk("done_total", done_seen, tgt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
